io_input_capture: RTL and testbench



---
 rtl/io_pkg.sv | 10 +
 rtl/io_tick_gen.sv | 28 ++
 rtl/io_input_capture.sv | 77 +++++++
 tb/tb_io_input_capture.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants for the tinymips memory-mapped IO devices.
package io_pkg;

  localparam int unsigned IO_WORD_W           = 32;
  localparam int unsigned IO_DEBOUNCE_DEFAULT = 16;

  localparam logic IO_REG_LEVEL = 1'b0;
  localparam logic IO_REG_EDGE  = 1'b1;

endpackage

// File: rtl/io_tick_gen.sv
// Free-running prescaler: tick is high for one cycle every PERIOD cycles.
module io_tick_gen #(
  parameter int unsigned PERIOD = 16
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tick = (count_q == LAST);

  always_comb begin
    count_d = count_q + 1'b1;
    if (tick) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/io_input_capture.sv
// Synchronised, debounced input port with sticky W1C rising-edge flags.
// Optional registered interrupt output enabled by `define IO_INPUT_IRQ_EN.
module io_input_capture
  import io_pkg::*;
#(
  parameter int unsigned WIDTH           = IO_WORD_W,
  parameter int unsigned DEBOUNCE_CYCLES = IO_DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic             a,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd,
  input  logic [WIDTH-1:0] iport,
  output logic             irq
);

  logic             tick;
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] flags_q, flags_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] agree;

  io_tick_gen #(
    .PERIOD (DEBOUNCE_CYCLES)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // A bit only moves when it reads the same value at two consecutive ticks.
  always_comb begin
    agree    = ~(sync2_q ^ prev_q);
    stable_d = stable_q;
    if (tick) stable_d = (agree & sync2_q) | (~agree & stable_q);
    rise     = stable_d & ~stable_q;
    clr      = (we && a == IO_REG_EDGE) ? wd : '0;
    flags_d  = (flags_q & ~clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      stable_q <= '0;
      flags_q  <= '0;
    end else begin
      sync1_q  <= iport;
      sync2_q  <= sync1_q;
      if (tick) prev_q <= sync2_q;
      stable_q <= stable_d;
      flags_q  <= flags_d;
    end
  end

  assign rd = (a == IO_REG_EDGE) ? flags_q : stable_q;

`ifdef IO_INPUT_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= |flags_q;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_io_input_capture.sv
// Directed scoreboard bench for io_input_capture with DEBOUNCE_CYCLES=4.
module tb_io_input_capture;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         we;
  logic         a;
  logic [W-1:0] wd;
  logic [W-1:0] rd;
  logic [W-1:0] iport;
  logic         irq;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  logic [W-1:0] exp_q[$];

`ifdef IO_INPUT_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  io_input_capture #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (we),
    .a       (a),
    .wd      (wd),
    .rd      (rd),
    .iport   (iport),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Counts edges since reset release; edge k is a debounce sample when k%4==0.
  always @(posedge clk) begin
    if (!reset_n) edge_n <= 0;
    else          edge_n <= edge_n + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check_rd(input logic sel, input string tag);
    logic [W-1:0] exp;
    a = sel;
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, rd=%h", tag, rd);
    end else begin
      exp = exp_q.pop_front();
      assert (rd === exp) else begin
        errors++;
        $error("FAIL %s: rd=%h expected %h", tag, rd, exp);
      end
    end
  endtask

  task automatic check_irq(input logic exp, input string tag);
    checks++;
    assert (irq === exp) else begin
      errors++;
      $error("FAIL %s: irq=%b expected %b", tag, irq, exp);
    end
  endtask

  task automatic wait_level(input logic [W-1:0] v, input int budget, input string tag);
    a = 1'b0;
    #1;
    for (int i = 0; i < budget && rd !== v; i++) step();
    push(v);
    check_rd(1'b0, tag);
  endtask

  task automatic write(input logic sel, input logic [W-1:0] d);
    we = 1'b1; a = sel; wd = d;
    step();
    we = 1'b0; wd = '0;
  endtask

  initial begin
    int m;
    reset_n = 1'b0; we = 1'b0; a = 1'b0; wd = '0; iport = '1;
    repeat (3) step();
    push('0); check_rd(1'b0, "reset_level");
    push('0); check_rd(1'b1, "reset_edge");
    check_irq(1'b0, "reset_irq");

    reset_n = 1'b1;
    wait_level('1, 10, "post_reset_level");
    push('1); check_rd(1'b1, "post_reset_edge");
    check_irq(1'b0, "irq_same_cycle_as_flag");
    step();
    check_irq(IRQ_ON, "irq_after_flag");

    write(1'b1, '1);
    push('0); check_rd(1'b1, "clear_all_edge");
    check_irq(IRQ_ON, "irq_during_clear_cycle");
    step();
    check_irq(1'b0, "irq_after_clear");

    iport = '0;
    wait_level('0, 10, "all_fall_level");
    push('0); check_rd(1'b1, "all_fall_edge");

    iport = 32'h1;
    repeat (2) step();
    iport = '0;
    repeat (12) step();
    push('0); check_rd(1'b0, "glitch_level");
    push('0); check_rd(1'b1, "glitch_edge");

    iport = 32'h8;
    wait_level(32'h8, 10, "hold3_level");
    push(32'h8); check_rd(1'b1, "hold3_edge");

    iport = 32'h9;
    wait_level(32'h9, 10, "bit0_level");
    push(32'h9); check_rd(1'b1, "bit0_edge");
    write(1'b1, 32'h1);
    push(32'h8); check_rd(1'b1, "w1c_bit0");
    write(1'b0, 32'hF);
    push(32'h8); check_rd(1'b1, "level_write_ignored");
    push(32'h9); check_rd(1'b0, "level_write_level");

    // Land the clear write on the very edge where bit 5 becomes stable.
    write(1'b1, '1);
    iport = 32'h29;
    m = ((edge_n + 3 + 3) / 4) * 4;
    for (int i = 0; i < 40 && edge_n < m + 3; i++) step();
    push(32'h9); check_rd(1'b0, "pre_collision_level");
    write(1'b1, 32'h20);
    push(32'h29); check_rd(1'b0, "collision_level");
    push(32'h20); check_rd(1'b1, "collision_set_wins");

    write(1'b1, '1);
    push('0); check_rd(1'b1, "pre_fall_clear");
    iport = 32'h21;
    wait_level(32'h21, 10, "fall3_level");
    push('0); check_rd(1'b1, "fall3_edge");
    check_irq(1'b0, "irq_no_flags");

    iport = 32'h121;
    wait_level(32'h121, 10, "bit8_level");
    push(32'h100); check_rd(1'b1, "bit8_edge");
    step();
    check_irq(IRQ_ON, "irq_bit8");
    reset_n = 1'b0;
    step();
    push('0); check_rd(1'b0, "midreset_level");
    push('0); check_rd(1'b1, "midreset_edge");
    check_irq(1'b0, "midreset_irq");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
